// File: rtl/grid_sweep_ctrl_pkg.sv
// Shared encodings for the grid sweep controller: sweep modes, FSM states
// and the mapping from a requested mode to the first sweep state.
package grid_sweep_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_CLEAR = 2'd0,
      MODE_READ  = 2'd1,
      MODE_WRITE = 2'd2,
      MODE_NOP   = 2'd3
   } sweep_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WRITE = 3'd4,
      ST_FIN   = 3'd5
   } sweep_state_t;

   // Wide enough to count the longest supported read latency.
   localparam int DRAIN_CNT_W = 3;

   function automatic sweep_state_t mode_target(input logic [1:0] mode);
      sweep_state_t target;
      case (sweep_mode_t'(mode))
         MODE_CLEAR: target = ST_CLEAR;
         MODE_READ:  target = ST_READ;
         MODE_WRITE: target = ST_WRITE;
         default:    target = ST_FIN;
      endcase
      return target;
   endfunction

endpackage

// File: rtl/grid_rd_pipe.sv
// Delay line that tracks issued grid reads so that data valid and its address
// line up with the bank q ports RD_LAT cycles later.
module grid_rd_pipe #(
   parameter int AW     = 4,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          issue,
   input  logic [AW-1:0] issue_addr,
   output logic          out_valid,
   output logic [AW-1:0] out_addr
);

   logic [RD_LAT-1:0] vld_q;
   logic [AW-1:0]     addr_q [RD_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
      end else if (flush) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
      end else begin
         vld_q[0]  <= issue;
         addr_q[0] <= issue_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[RD_LAT-1];
   assign out_addr  = vld_q[RD_LAT-1] ? addr_q[RD_LAT-1] : '0;

endmodule

// File: rtl/grid_sweep_ctrl.sv
// Sweep controller that drives a DIMENSION x DIMENSION array of grid memory
// banks in lockstep through clear, read and streamed-write passes.
module grid_sweep_ctrl
   import grid_sweep_ctrl_pkg::*;
#(
   parameter int GRID_ADDRESS_WIDTH = 4,
   parameter int DIMENSION          = 16,
   parameter int RD_LAT             = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [1:0]                    mode,
   input  logic                          abort,
   output logic                          busy,
   output logic                          done,
   output logic [GRID_ADDRESS_WIDTH-1:0] rd_addr,
   output logic [GRID_ADDRESS_WIDTH-1:0] wr_addr,
   output logic                          wren,
   output logic                          wr_zero,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          out_valid,
   output logic [GRID_ADDRESS_WIDTH-1:0] out_addr,
   output sweep_state_t                  fsm_state
);

   localparam logic [GRID_ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(RD_LAT - 1);

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("grid_sweep_ctrl: RD_LAT must be within 1..4");
   end
   if (DIMENSION < 1) begin : g_bad_dimension
      $error("grid_sweep_ctrl: DIMENSION must be at least 1");
   end

   sweep_state_t                  state_q, state_d;
   logic [GRID_ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
   logic [DRAIN_CNT_W-1:0]        drain_q, drain_d;
   logic                          issue;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end
   end

   // Handshake: a write beat moves on any cycle where in_valid and in_ready
   // are both high; in_ready is high for the whole WRITE state and nowhere else.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      drain_d  = drain_q;
      busy     = (state_q != ST_IDLE);
      done     = 1'b0;
      wren     = 1'b0;
      wr_zero  = 1'b0;
      in_ready = 1'b0;
      rd_addr  = '0;
      wr_addr  = '0;
      issue    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            drain_d = '0;
            if (start) state_d = mode_target(mode);
         end
         ST_CLEAR: begin
            wren    = 1'b1;
            wr_zero = 1'b1;
            wr_addr = cnt_q;
            if (cnt_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = ST_FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_READ: begin
            rd_addr = cnt_q;
            issue   = 1'b1;
            if (cnt_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               drain_d = '0;
               state_d = ST_FIN;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         ST_WRITE: begin
            in_ready = 1'b1;
            wr_addr  = cnt_q;
            if (in_valid) begin
               wren = 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  cnt_d   = '0;
                  state_d = ST_FIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_FIN: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort wins over every transition, including a start seen in IDLE.
      if (abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         drain_d = '0;
         done    = 1'b0;
      end
   end

   grid_rd_pipe #(
      .AW     (GRID_ADDRESS_WIDTH),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk        (clk),
      .rst        (rst),
      .flush      (abort),
      .issue      (issue),
      .issue_addr (rd_addr),
      .out_valid  (out_valid),
      .out_addr   (out_addr)
   );

   assign fsm_state = state_q;

endmodule

// File: tb/tb_grid_sweep_ctrl.sv
// Bench for grid_sweep_ctrl: per-cycle expectation tables built from the sweep
// rules, scripted corner sweeps, then randomized sweeps with random aborts.
module tb_grid_sweep_ctrl;
   import grid_sweep_ctrl_pkg::*;

   localparam int AW   = 4;
   localparam int N    = 16;
   localparam int L    = 2;
   localparam int MAXC = 4096;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort, in_valid;
   logic [1:0]    mode;
   logic          busy, done, wren, wr_zero, in_ready, out_valid;
   logic [AW-1:0] rd_addr, wr_addr, out_addr;
   sweep_state_t  fsm_state;

   grid_sweep_ctrl #(
      .GRID_ADDRESS_WIDTH (AW),
      .DIMENSION          (16),
      .RD_LAT             (L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .wr_addr   (wr_addr),
      .wren      (wren),
      .wr_zero   (wr_zero),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_addr  (out_addr),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   // Stimulus tables, indexed by cycle number
   bit            d_start [MAXC];
   bit            d_abort [MAXC];
   bit            d_inv   [MAXC];
   logic [1:0]    d_mode  [MAXC];
   // Expected outputs, indexed by cycle number
   bit            e_busy [MAXC], e_done [MAXC], e_wren [MAXC], e_wr_zero [MAXC];
   bit            e_in_ready [MAXC], e_ov [MAXC], e_rd_chk [MAXC];
   logic [AW-1:0] e_wr_addr [MAXC], e_out_addr [MAXC], e_rd_addr [MAXC];

   int cyc = 0;
   bit chk_en = 1'b0;
   int pass_cnt = 0;
   int total_cnt = 0;
   int mon_done_cnt, mon_last_done, mon_wren_cnt, mon_busy_cnt;
   int mon_first_ov, mon_last_ov, mon_ov_cnt, mon_first_wr_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic clear_exp(input int x);
      e_busy[x] = 0; e_done[x] = 0; e_wren[x] = 0; e_wr_zero[x] = 0;
      e_in_ready[x] = 0; e_ov[x] = 0; e_rd_chk[x] = 0;
   endtask

   // Builds stimulus and expectations for one sweep started at cycle t0.
   // pat: 0 = in_valid always high, 1 = toggling 1,0,..., 2 = random.
   // ab: -1 no abort, -2 random abort offset, else abort offset from t0.
   task automatic plan_sweep(input int t0, input logic [1:0] m, input int pat,
                             input int ab, output int last);
      int c, beats, j, a;
      bit v;
      c = t0 + 1;
      d_start[t0] = 1'b1;
      d_mode[t0]  = m;
      d_abort[t0] = 1'b0;
      case (m)
         2'd0: for (int k = 0; k < N; k++) begin
            e_busy[c] = 1; e_wren[c] = 1; e_wr_zero[c] = 1; e_wr_addr[c] = AW'(k);
            c++;
         end
         2'd1: begin
            for (int k = 0; k < N; k++) begin
               e_busy[c] = 1; e_rd_chk[c] = 1; e_rd_addr[c] = AW'(k);
               e_ov[c+L] = 1; e_out_addr[c+L] = AW'(k);
               c++;
            end
            for (int k = 0; k < L; k++) begin
               e_busy[c] = 1;
               c++;
            end
         end
         2'd2: begin
            beats = 0;
            j = 0;
            while (beats < N) begin
               e_busy[c] = 1; e_in_ready[c] = 1;
               if (pat == 0) v = 1'b1;
               else if (pat == 1) v = (j % 2 == 0);
               else v = 1'($urandom_range(0, 1));
               d_inv[c] = v;
               if (v) begin
                  e_wren[c] = 1; e_wr_addr[c] = AW'(beats);
                  beats++;
               end
               c++;
               j++;
            end
         end
         default: ;
      endcase
      e_busy[c] = 1;
      e_done[c] = 1;
      last = c;
      a = (ab == -2) ? int'($urandom_range(1, c - t0)) : ab;
      if (a >= 0) begin
         d_abort[t0+a] = 1'b1;
         e_done[t0+a]  = 0;
         for (int x = t0 + a + 1; x <= c + L + 1; x++) clear_exp(x);
         last = t0 + a;
      end
      for (int x = t0 + 1; x <= last; x++) begin
         d_start[x] = ($urandom_range(0, 3) == 0);
         d_mode[x]  = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic mon_reset();
      mon_done_cnt = 0; mon_last_done = -1; mon_wren_cnt = 0; mon_busy_cnt = 0;
      mon_first_ov = -1; mon_last_ov = -1; mon_ov_cnt = 0; mon_first_wr_addr = -1;
   endtask

   task automatic wait_cycle(input int c);
      do @(negedge clk); while (cyc < c);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_wren"}, wren, 0);
      chk({tag, "_wr_zero"}, wr_zero, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_out_addr"}, out_addr, 0);
      chk({tag, "_state"}, fsm_state, ST_IDLE);
   endtask

   // Driver: applies the stimulus tables shortly after each rising edge
   initial begin
      start = 0; abort = 0; mode = 0; in_valid = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (cyc >= MAXC - 8) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 8);
            $fatal(1, "cycle budget exhausted");
         end
         #1;
         start    = d_start[cyc];
         abort    = d_abort[cyc];
         mode     = d_mode[cyc];
         in_valid = d_inv[cyc];
      end
   end

   // Compare process: every cycle, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("busy", busy, e_busy[cyc]);
            chk("done", done, e_done[cyc]);
            chk("wren", wren, e_wren[cyc]);
            chk("wr_zero", wr_zero, e_wr_zero[cyc]);
            chk("in_ready", in_ready, e_in_ready[cyc]);
            chk("out_valid", out_valid, e_ov[cyc]);
            if (e_wren[cyc]) chk("wr_addr", wr_addr, e_wr_addr[cyc]);
            if (e_ov[cyc]) chk("out_addr", out_addr, e_out_addr[cyc]);
            if (e_rd_chk[cyc]) chk("rd_addr", rd_addr, e_rd_addr[cyc]);
            if (done) begin mon_done_cnt++; mon_last_done = cyc; end
            if (busy) mon_busy_cnt++;
            if (wren) begin
               if (mon_wren_cnt == 0) mon_first_wr_addr = int'(wr_addr);
               mon_wren_cnt++;
            end
            if (out_valid) begin
               if (mon_first_ov < 0) mon_first_ov = cyc;
               mon_last_ov = cyc;
               mon_ov_cnt++;
            end
         end
      end
   end

   initial begin
      int t0, t1, last, last1, gap, pat, ab;
      logic [1:0] m;
      rst = 1'b1;
      for (int i = 0; i < MAXC; i++) begin
         d_start[i] = 0; d_abort[i] = 0;
         d_inv[i] = 1'($urandom_range(0, 1));
         d_mode[i] = 2'($urandom_range(0, 3));
         clear_exp(i);
         e_wr_addr[i] = '0; e_out_addr[i] = '0; e_rd_addr[i] = '0;
      end
      mon_reset();
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // CLEAR, with an extra start mid-sweep that must be ignored
      mon_reset();
      t0 = cyc + 2;
      plan_sweep(t0, 2'd0, 0, -1, last);
      d_start[t0+5] = 1'b1;
      wait_cycle(last + 2);
      chk("clear_wren_cnt", mon_wren_cnt, 16);
      chk("clear_done_ofs", mon_last_done - t0, 17);
      chk("clear_busy_cnt", mon_busy_cnt, 17);
      chk("clear_done_cnt", mon_done_cnt, 1);

      // READ
      mon_reset();
      t0 = cyc + 2;
      plan_sweep(t0, 2'd1, 0, -1, last);
      wait_cycle(last + 2);
      chk("read_first_ov", mon_first_ov - t0, 3);
      chk("read_last_ov", mon_last_ov - t0, 18);
      chk("read_ov_cnt", mon_ov_cnt, 16);
      chk("read_done_ofs", mon_last_done - t0, 19);

      // WRITE with in_valid toggling
      mon_reset();
      t0 = cyc + 2;
      plan_sweep(t0, 2'd2, 1, -1, last);
      wait_cycle(last + 2);
      chk("write_wren_cnt", mon_wren_cnt, 16);
      chk("write_done_ofs", mon_last_done - t0, 32);

      // Reserved mode: only a done pulse
      mon_reset();
      t0 = cyc + 2;
      plan_sweep(t0, 2'd3, 0, -1, last);
      wait_cycle(last + 2);
      chk("nop_done_ofs", mon_last_done - t0, 1);
      chk("nop_wren_cnt", mon_wren_cnt, 0);

      // Abort while issuing READ address 7, then an immediate new CLEAR
      mon_reset();
      t0 = cyc + 2;
      plan_sweep(t0, 2'd1, 0, 8, last);
      t1 = last + 1;
      plan_sweep(t1, 2'd0, 0, -1, last1);
      wait_cycle(t1 - 1);
      chk("abort_done_cnt", mon_done_cnt, 0);
      chk("abort_last_ov", mon_last_ov - t0, 8);
      wait_cycle(last1 + 2);
      chk("after_abort_done_ofs", mon_last_done - t1, 17);

      // start and abort together in IDLE
      mon_reset();
      t0 = cyc + 2;
      d_start[t0] = 1'b1;
      d_abort[t0] = 1'b1;
      wait_cycle(t0 + 4);
      chk("start_abort_busy_cnt", mon_busy_cnt, 0);

      // Asynchronous reset during WRITE beat 5
      mon_reset();
      t0 = cyc + 2;
      plan_sweep(t0, 2'd2, 0, 6, last);
      wait_cycle(t0 + 6);
      chk("pre_rst_wr_addr", wr_addr, 5);
      #1 rst = 1'b1;
      #1 chk_all_zero("async_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      mon_reset();
      t0 = cyc + 2;
      plan_sweep(t0, 2'd2, 2, -1, last);
      wait_cycle(last + 2);
      chk("rst_restart_addr", mon_first_wr_addr, 0);
      chk("rst_restart_wren", mon_wren_cnt, 16);

      // Randomized sweeps with occasional aborts
      for (int n = 0; n < 30; n++) begin
         gap = $urandom_range(0, 3);
         m   = 2'($urandom_range(0, 3));
         pat = $urandom_range(0, 2);
         ab  = ($urandom_range(0, 3) == 0) ? -2 : -1;
         t0  = cyc + 2 + gap;
         plan_sweep(t0, m, pat, ab, last);
         wait_cycle(last + 2);
      end

      wait_cycle(cyc + 3);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
